ysyx_24110015_lsu: RTL and testbench

- Load/store unit. Consumer end of the EXU→LSU interface: takes the EXU outputs (ALU result/address, funct3, store data, read/write enables, writeback target) and performs the memory access.
- Drives a single-outstanding request/response memory bus.
- Returns an aligned, sign/zero-extended result to writeback over a valid/ready handshake.
- Non-memory instructions pass straight through with one cycle of latency.

---
 rtl/ysyx_24110015_lsu_pkg.sv | 29 ++
 rtl/ysyx_24110015_lsu_align.sv | 52 +++++
 rtl/ysyx_24110015_lsu.sv | 141 ++++++++++++++
 tb/tb_ysyx_24110015_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared types for the load/store unit: FSM state, func3 encodings, bus request/response bundles.
package ysyx_24110015_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } lsu_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } lsu_rsp_t;

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, load extract/extension, misalignment flag.
module ysyx_24110015_lsu_align
    import ysyx_24110015_lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [15:0] ld_half;

    assign ld_half = 16'(ld_word >> {offset, 3'b000});

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b0000;
        ld_data  = ld_word;
        misalign = 1'b0;
        case (func3)
            F3_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << offset;
                ld_data  = {{24{ld_half[7]}}, ld_half[7:0]};
            end
            F3_BU: begin
                ld_data  = {24'h0, ld_half[7:0]};
            end
            F3_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << offset;
                ld_data  = {{16{ld_half[15]}}, ld_half};
                misalign = (offset == 2'd3);
            end
            F3_HU: begin
                ld_data  = {16'h0, ld_half};
                misalign = (offset == 2'd3);
            end
            F3_W: begin
                // Misaligned words keep only the lanes that fit in this word.
                st_wstrb = 4'b1111 << offset;
                misalign = (offset != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: single-outstanding memory bus master with valid/ready result to writeback.
// Optional trap on misaligned access: define YSYX_24110015_LSU_MISALIGN_TRAP_EN.
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_out,
    input  logic [2:0]      func3,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic            reg_wen_i,
    input  logic [4:0]      wb_addr_i,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    input  logic            mem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            reg_wen_o,
    output logic [4:0]      wb_addr_o,
    output logic            out_err
);

`ifdef YSYX_24110015_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_e  state_reg, state_next;
    lsu_req_t    req_reg;
    lsu_rsp_t    rsp;
    logic [2:0]  func3_reg;
    logic [1:0]  off_reg;
    logic        is_load_reg;
    logic        reg_wen_reg;
    logic [4:0]  wb_addr_reg;
    logic [31:0] result_reg;
    logic        err_reg;

    logic        accept, is_mem, trap, misalign;
    logic [2:0]  func3_sel;
    logic [1:0]  off_sel;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    assign in_ready  = (state_reg == S_IDLE);
    assign accept    = in_valid & in_ready;
    assign is_mem    = mem_read | mem_write;
    assign trap      = TRAP_EN & is_mem & misalign;
    assign rsp       = '{rdata: mem_rsp_rdata, err: mem_rsp_err};

    // While idle the lanes are computed from the incoming bundle, afterwards from the captured one.
    assign func3_sel = in_ready ? func3 : func3_reg;
    assign off_sel   = in_ready ? alu_out[1:0] : off_reg;

    ysyx_24110015_lsu_align u_align (
        .func3    (func3_sel),
        .offset   (off_sel),
        .st_data  (mem_wdata),
        .ld_word  (rsp.rdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = (is_mem && !trap) ? S_REQ : S_DONE;
            S_REQ:  if (mem_req_ready) state_next = S_RSP;
            S_RSP:  if (mem_rsp_valid) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_reg     <= '0;
            func3_reg   <= 3'b000;
            off_reg     <= 2'b00;
            is_load_reg <= 1'b0;
            reg_wen_reg <= 1'b0;
            wb_addr_reg <= 5'd0;
            result_reg  <= 32'h0;
            err_reg     <= 1'b0;
        end else begin
            if (accept) begin
                func3_reg   <= func3;
                off_reg     <= alu_out[1:0];
                is_load_reg <= mem_read & ~mem_write;
                reg_wen_reg <= reg_wen_i & ~trap;
                wb_addr_reg <= wb_addr_i;
                result_reg  <= alu_out;
                err_reg     <= trap;
                if (is_mem && !trap) begin
                    req_reg.wen   <= mem_write;
                    req_reg.addr  <= {alu_out[31:2], 2'b00};
                    req_reg.wdata <= st_wdata;
                    req_reg.wstrb <= mem_write ? st_wstrb : 4'b0000;
                end
            end
            if (state_reg == S_RSP && mem_rsp_valid) begin
                err_reg <= rsp.err;
                if (rsp.err) reg_wen_reg <= 1'b0;
                if (is_load_reg) result_reg <= ld_data;
            end
        end
    end

    assign mem_req_valid = (state_reg == S_REQ);
    assign mem_req_wen   = req_reg.wen;
    assign mem_req_addr  = req_reg.addr;
    assign mem_req_wdata = req_reg.wdata;
    assign mem_req_wstrb = req_reg.wstrb;
    assign out_valid     = (state_reg == S_DONE);
    assign result        = result_reg;
    assign reg_wen_o     = reg_wen_reg;
    assign wb_addr_o     = wb_addr_reg;
    assign out_err       = err_reg;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_ysyx_24110015_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] alu_out = '0;
    logic [2:0]  func3 = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        reg_wen_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        mem_rsp_err = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] result;
    logic        reg_wen_o;
    logic [4:0]  wb_addr_o;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    // Observations from the last run_txn call.
    logic        obs_req_seen, obs_wen, obs_err, obs_reg_wen;
    logic [31:0] obs_addr, obs_wdata, obs_result;
    logic [3:0]  obs_wstrb;
    logic [4:0]  obs_wb;
    int          obs_lat, stable_bad;

    always #5 clk = ~clk;

    ysyx_24110015_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .func3(func3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .reg_wen_i(reg_wen_i), .wb_addr_i(wb_addr_i),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .reg_wen_o(reg_wen_o), .wb_addr_o(wb_addr_o), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"},  in_ready, 1);
        check({pfx, "_req_valid"}, mem_req_valid, 0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_result"},    result, 0);
        check({pfx, "_reg_wen"},   reg_wen_o, 0);
        check({pfx, "_wb_addr"},   wb_addr_o, 0);
        check({pfx, "_out_err"},   out_err, 0);
        check({pfx, "_req_wen"},   mem_req_wen, 0);
        check({pfx, "_req_addr"},  mem_req_addr, 0);
        check({pfx, "_req_wdata"}, mem_req_wdata, 0);
        check({pfx, "_req_wstrb"}, mem_req_wstrb, 0);
    endtask

    task automatic send(input logic [31:0] a, input logic [2:0] f3, input logic rd,
                        input logic wr, input logic [31:0] wd);
        @(negedge clk);
        alu_out = a; func3 = f3; mem_read = rd; mem_write = wr; mem_wdata = wd;
        reg_wen_i = 1'b1; wb_addr_i = 5'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_wen_i = 1'b0;
    endtask

    // One full transaction with a responsive bus model and configurable backpressure.
    task automatic run_txn(input logic [31:0] a, input logic [2:0] f3, input logic rd, input logic wr,
                           input logic [31:0] wd, input logic [31:0] rdata, input logic err,
                           input int req_wait, input int out_wait);
        int  cyc;
        int  waited;
        logic done;
        out_ready = 1'b0;
        mem_req_ready = 1'b0;
        send(a, f3, rd, wr, wd);
        cyc = 0; waited = 0; done = 1'b0;
        obs_req_seen = 1'b0; stable_bad = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (in_ready) stable_bad++;
            if (out_valid) begin
                done = 1'b1;
            end else if (mem_req_valid) begin
                if (!obs_req_seen) begin
                    obs_req_seen = 1'b1;
                    obs_wen = mem_req_wen; obs_addr = mem_req_addr;
                    obs_wdata = mem_req_wdata; obs_wstrb = mem_req_wstrb;
                end else if (mem_req_wen !== obs_wen || mem_req_addr !== obs_addr ||
                             mem_req_wdata !== obs_wdata || mem_req_wstrb !== obs_wstrb) begin
                    stable_bad++;
                end
                if (waited == req_wait) begin
                    mem_req_ready = 1'b1;
                    @(posedge clk);
                    #1 mem_req_ready = 1'b0;
                    @(negedge clk);
                    cyc++;
                    if (mem_req_valid || in_ready || out_valid) stable_bad++;
                    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata; mem_rsp_err = err;
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
                end
                waited++;
            end
        end
        if (!done) begin
            $display("FAIL txn_timeout: no out_valid within 64 cycles at addr 0x%08h", a);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
            $fatal(1, "timeout");
        end
        obs_lat = cyc;
        obs_result = result; obs_err = out_err; obs_reg_wen = reg_wen_o; obs_wb = wb_addr_o;
        for (int i = 0; i < out_wait; i++) begin
            @(negedge clk);
            if (!out_valid || result !== obs_result || in_ready || mem_req_valid) stable_bad++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        if (!in_ready || out_valid) stable_bad++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b1;

        // Pass-through
        run_txn(32'h0000_1234, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        check("pt_lat", obs_lat, 1);
        check("pt_result", obs_result, 32'h0000_1234);
        check("pt_no_req", obs_req_seen, 0);
        check("pt_reg_wen", obs_reg_wen, 1);
        check("pt_wb_addr", obs_wb, 7);
        check("pt_handshake", stable_bad, 0);

        // LB / LBU at offset 3
        run_txn(32'h8000_0003, 3'b000, 1, 0, 0, 32'h80FF_FFFF, 0, 0, 0);
        check("lb_lat", obs_lat, 3);
        check("lb_addr", obs_addr, 32'h8000_0000);
        check("lb_wen", obs_wen, 0);
        check("lb_wstrb", obs_wstrb, 0);
        check("lb_result", obs_result, 32'hFFFF_FF80);
        run_txn(32'h8000_0003, 3'b100, 1, 0, 0, 32'h80FF_FFFF, 0, 0, 0);
        check("lbu_result", obs_result, 32'h0000_0080);

        // LH / LHU at offset 2
        run_txn(32'h8000_0006, 3'b001, 1, 0, 0, 32'h8001_1234, 0, 0, 0);
        check("lh_addr", obs_addr, 32'h8000_0004);
        check("lh_result", obs_result, 32'hFFFF_8001);
        run_txn(32'h8000_0006, 3'b101, 1, 0, 0, 32'h8001_1234, 0, 0, 0);
        check("lhu_result", obs_result, 32'h0000_8001);

        // SH at offset 2
        run_txn(32'h8000_0002, 3'b001, 0, 1, 32'h0000_ABCD, 0, 0, 0, 0);
        check("sh_addr", obs_addr, 32'h8000_0000);
        check("sh_wstrb", obs_wstrb, 4'b1100);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh_wen", obs_wen, 1);

        // SB at offset 1, with read also set: store wins
        run_txn(32'h8000_0101, 3'b000, 1, 1, 32'h1234_56A5, 0, 0, 0, 0);
        check("sb_wstrb", obs_wstrb, 4'b0010);
        check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        check("sb_wen", obs_wen, 1);

        // SW with request and output backpressure
        run_txn(32'h8000_0010, 3'b010, 0, 1, 32'h1122_3344, 0, 0, 5, 3);
        check("bp_stable", stable_bad, 0);
        check("bp_lat", obs_lat, 8);
        check("bp_wstrb", obs_wstrb, 4'b1111);
        check("bp_wdata", obs_wdata, 32'h1122_3344);

        // LW with bus error
        run_txn(32'h8000_0020, 3'b010, 1, 0, 0, 32'hDEAD_BEEF, 1, 0, 0);
        check("err_out_err", obs_err, 1);
        check("err_reg_wen", obs_reg_wen, 0);

        // Misaligned LW
        run_txn(32'h8000_0001, 3'b010, 1, 0, 0, 32'hCAFE_F00D, 0, 0, 0);
`ifdef YSYX_24110015_LSU_MISALIGN_TRAP_EN
        check("mis_no_req", obs_req_seen, 0);
        check("mis_out_err", obs_err, 1);
        check("mis_result", obs_result, 32'h8000_0001);
        check("mis_reg_wen", obs_reg_wen, 0);
`else
        check("mis_req", obs_req_seen, 1);
        check("mis_addr", obs_addr, 32'h8000_0000);
        check("mis_out_err", obs_err, 0);
        check("mis_result", obs_result, 32'hCAFE_F00D);
`endif

        // Reset asserted while waiting for the response
        send(32'h8000_0040, 3'b010, 1, 0, 0);
        @(negedge clk);
        check("rr_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst1");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_out_valid", out_valid, 0);
        check("late_rsp_in_ready", in_ready, 1);
        check("late_rsp_result", result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
